mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single multi-cycle main memory between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. Accepts one request at a time, latches its address, sequences the eight-word block read (or the single-word write) against the pipelined memory, and routes returning words back to the owning cache with data/tag write enables and a stall signal. Sits between the two caches and the memory model in the memory stage of the pipeline.

## Interface
- MEM_LATENCY, 4, cycles from a read issue (mem_enable high, mem_wr low) to its mem_data_valid
- WORDS, 8, 16-bit words per cache block (fixed at 8 for 16-byte blocks)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- i_miss_req  in  1  I-cache miss pending (level, held until i_tag_we)
- i_miss_addr  in  16  I-cache missing address
- d_miss_req  in  1  D-cache miss pending (level)
- d_miss_addr  in  16  D-cache missing address
- d_wr_req  in  1  D-cache store pending (level, held until d_wr_ack)
- d_wr_addr  in  16  store address
- d_wr_data  in  16  store data
- mem_data_out  in  16  memory read data
- mem_data_valid  in  1  mem_data_out valid this cycle
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  access is a write
- mem_addr  out  16  memory address
- mem_data_in  out  16  memory write data
- i_busy / d_busy  out  1 each  stall: owner side is being served
- i_data_we / d_data_we  out  1 each  write returning word into that cache's data array
- i_tag_we / d_tag_we  out  1 each  final word written; write tag/valid
- fill_addr  out  16  address of returning word
- fill_data  out  16  returning word (mem_data_out passthrough)
- d_wr_ack  out  1  store performed this cycle

## Operation
- States: IDLE, FILL_I, FILL_D, WRITE. Registered state, 2-bit.
- IDLE arbitration priority: d_wr_req > d_miss_req > i_miss_req, except fairness flag last_d: if last_d=1 and i_miss_req=1, I-fill wins over D requests. last_d set on completing any D transaction, cleared on completing an I-fill. Reset 0.
- On grant: base = addr[15:4] latched (fills); store addr/data latched (write). No preemption; request deassertion after grant is ignored.
- FILL_x: issue counter ic (4-bit, 0..8) drives mem_enable=1, mem_wr=0, mem_addr={base,ic[2:0],1'b0} while ic<8; ic increments each cycle. Receive counter rc (4-bit) increments on each mem_data_valid; fill_addr={base,rc[2:0],1'b0}; x_data_we=mem_data_valid. When mem_data_valid and rc==7: x_tag_we=1, state -> IDLE, counters clear.
- WRITE: one cycle, mem_enable=1, mem_wr=1, mem_addr/mem_data_in = latched store, d_wr_ack=1; -> IDLE.
- x_busy=1 whenever state is FILL_x (d_busy also in WRITE) and also in IDLE the cycle the corresponding request is granted.
- mem_data_valid in IDLE or WRITE is a stale return: ignored, no write enables.
- Reset (any state): state IDLE, ic=rc=0, last_d=0, all outputs 0 next cycle; in-flight returns after reset dropped.

## Timing
- All outputs 0 during and after reset until a grant.
- Request seen in IDLE at cycle 0 -> busy at 0, first read issue at cycle 1, issues cycles 1..8, returns cycles 5..12 (MEM_LATENCY=4), tag_we cycle 12, IDLE cycle 13, next issue earliest cycle 14. Fill = 13 cycles request-to-tag_we.
- Store: request cycle 0 -> mem write and d_wr_ack cycle 1, IDLE cycle 2.
- Gaps in mem_data_valid tolerated; completion counts valid pulses only.

## Test plan
- I miss 0x1234 alone -> mem_addr 0x1230,0x1232..0x123E cycles 1-8; i_data_we cycles 5-12 with fill_addr matching; i_tag_we only cycle 12; d_* stay 0.
- i_miss_req and d_miss_req together at cycle 0 (last_d=0) -> D fill cycles 1-12, I fill issues from cycle 14, i_busy high throughout.
- d_wr_req (0x0040, data 0xBEEF) with d_miss_req -> write at cycle 1 with d_wr_ack, D fill issues from cycle 3.
- Fairness: back-to-back D requests with I pending -> after first D completes, I granted next, not second D.
- rst_n low at cycle 6 of fill -> IDLE next edge, all outputs 0; later mem_data_valid pulses cause no data_we/tag_we.
- Memory stalls valid two cycles mid-block -> still exactly 8 data_we, tag_we on 8th valid.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the two cache controllers and the
// pipelined main memory. The slave modport is the arbiter's view; the master
// modport is the view of the environment (caches plus memory).
interface mem_arbiter_if;
  // cache-side requests
  logic        i_miss_req;
  logic [15:0] i_miss_addr;
  logic        d_miss_req;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  // memory side
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  // cache-side responses
  logic        i_busy;
  logic        d_busy;
  logic        i_data_we;
  logic        d_data_we;
  logic        i_tag_we;
  logic        d_tag_we;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        d_wr_ack;

  modport slave (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
    output mem_enable, mem_wr, mem_addr, mem_data_in,
    output i_busy, d_busy, i_data_we, d_data_we, i_tag_we, d_tag_we,
    output fill_addr, fill_data, d_wr_ack
  );

  modport master (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
    input  mem_enable, mem_wr, mem_addr, mem_data_in,
    input  i_busy, d_busy, i_data_we, d_data_we, i_tag_we, d_tag_we,
    input  fill_addr, fill_data, d_wr_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: grants one of I-fill, D-fill or D-store at a time, issues
// the eight pipelined block reads (or the single write) and steers the
// returning words to the owning cache. Completion counts valid pulses, so
// memory-side gaps are tolerated; returns outside a fill are dropped.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL_I = 2'd1, FILL_D = 2'd2, WRITE = 2'd3} state_t;

  // block size is fixed at eight 16-bit words (16-byte lines)
  localparam logic [3:0] WORDS     = 4'd8;
  localparam logic [3:0] LAST_WORD = WORDS - 4'd1;

  state_t      state_reg, state_next;
  logic [3:0]  ic_reg, ic_next;
  logic [3:0]  rc_reg, rc_next;
  logic [11:0] base_reg, base_next;
  logic [15:0] wr_addr_reg, wr_addr_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic        last_d_reg, last_d_next;

  logic        grant_i, grant_d, grant_w;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_in;
  logic        i_busy, d_busy, i_data_we, d_data_we, i_tag_we, d_tag_we, d_wr_ack;

  // word offset of a miss address is irrelevant: whole blocks are fetched
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_miss_addr[3:0], bus.d_miss_addr[3:0]};

  // Arbitration: store > D miss > I miss, but a waiting I miss wins right
  // after a D transaction so the instruction side cannot be starved.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    grant_w = 1'b0;
    if (bus.i_miss_req && last_d_reg) grant_i = 1'b1;
    else if (bus.d_wr_req)            grant_w = 1'b1;
    else if (bus.d_miss_req)          grant_d = 1'b1;
    else if (bus.i_miss_req)          grant_i = 1'b1;
  end

  // Next-state and output decode; every output is held at 0 while in reset.
  always_comb begin
    state_next   = state_reg;
    ic_next      = ic_reg;
    rc_next      = rc_reg;
    base_next    = base_reg;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    last_d_next  = last_d_reg;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_data_in  = 16'h0000;
    i_busy       = 1'b0;
    d_busy       = 1'b0;
    i_data_we    = 1'b0;
    d_data_we    = 1'b0;
    i_tag_we     = 1'b0;
    d_tag_we     = 1'b0;
    d_wr_ack     = 1'b0;
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          // stale memory returns are simply ignored here
          if (grant_w) begin
            d_busy       = 1'b1;
            wr_addr_next = bus.d_wr_addr;
            wr_data_next = bus.d_wr_data;
            state_next   = WRITE;
          end else if (grant_d) begin
            d_busy     = 1'b1;
            base_next  = bus.d_miss_addr[15:4];
            state_next = FILL_D;
          end else if (grant_i) begin
            i_busy     = 1'b1;
            base_next  = bus.i_miss_addr[15:4];
            state_next = FILL_I;
          end
        end
        FILL_I, FILL_D: begin
          i_busy = (state_reg == FILL_I);
          d_busy = (state_reg == FILL_D);
          // issue side runs ahead of the returns, one read per cycle
          if (ic_reg < WORDS) begin
            mem_enable = 1'b1;
            mem_addr   = {base_reg, ic_reg[2:0], 1'b0};
            ic_next    = ic_reg + 4'd1;
          end
          if (bus.mem_data_valid) begin
            i_data_we = i_busy;
            d_data_we = d_busy;
            if (rc_reg == LAST_WORD) begin
              i_tag_we    = i_busy;
              d_tag_we    = d_busy;
              last_d_next = d_busy;
              ic_next     = 4'd0;
              rc_next     = 4'd0;
              state_next  = IDLE;
            end else begin
              rc_next = rc_reg + 4'd1;
            end
          end
        end
        default: begin
          // WRITE: single-cycle store of the latched address/data
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = wr_addr_reg;
          mem_data_in = wr_data_reg;
          d_busy      = 1'b1;
          d_wr_ack    = 1'b1;
          last_d_next = 1'b1;
          state_next  = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ic_reg      <= 4'd0;
      rc_reg      <= 4'd0;
      base_reg    <= 12'h000;
      wr_addr_reg <= 16'h0000;
      wr_data_reg <= 16'h0000;
      last_d_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ic_reg      <= ic_next;
      rc_reg      <= rc_next;
      base_reg    <= base_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      last_d_reg  <= last_d_next;
    end
  end

  assign bus.mem_enable  = mem_enable;
  assign bus.mem_wr      = mem_wr;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_data_in = mem_data_in;
  assign bus.i_busy      = i_busy;
  assign bus.d_busy      = d_busy;
  assign bus.i_data_we   = i_data_we;
  assign bus.d_data_we   = d_data_we;
  assign bus.i_tag_we    = i_tag_we;
  assign bus.d_tag_we    = d_tag_we;
  assign bus.d_wr_ack    = d_wr_ack;
  assign bus.fill_addr   = {base_reg, rc_reg[2:0], 1'b0};
  assign bus.fill_data   = bus.mem_data_out;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: pipelined memory model with optional stalls,
// cache requesters that drop their request on completion, and a
// transaction-level reference model of the arbiter checked every cycle.
module tb_mem_arbiter;
  localparam int MEM_LATENCY = 4;

  logic clk = 1'b0;
  logic rst_n;
  mem_arbiter_if bus ();

  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int ready; logic [15:0] addr; } rd_t;
  rd_t mq[$];
  int  cyc;
  bit  stall_now;
  int  n_tests, n_fail;

  // observed outputs, sampled mid-cycle
  logic        o_en, o_wr, o_ib, o_db, o_idwe, o_ddwe, o_itwe, o_dtwe, o_ack, o_valid;
  logic [15:0] o_addr, o_din, o_faddr, o_fdata;
  logic [40:0] obs_ctrl, exp_ctrl;
  logic [31:0] obs_fill, exp_fill;

  // reference model: owner 0 none, 1 I-fill, 2 D-fill, 3 store
  int          m_owner, m_grant, m_iss, m_rcv;
  bit          m_last_d;
  logic [15:0] m_base, m_waddr, m_wdata;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA55A;
  endfunction

  task automatic model_expect();
    logic en, wr, ib, db, idwe, ddwe, itwe, dtwe, ack;
    logic [15:0] addr, din, faddr;
    en = 0; wr = 0; ib = 0; db = 0; idwe = 0; ddwe = 0; itwe = 0; dtwe = 0; ack = 0;
    addr = 16'h0; din = 16'h0; faddr = 16'h0; m_grant = 0;
    if (rst_n) begin
      case (m_owner)
        0: begin
          if (bus.i_miss_req && m_last_d) m_grant = 1;
          else if (bus.d_wr_req)          m_grant = 3;
          else if (bus.d_miss_req)        m_grant = 2;
          else if (bus.i_miss_req)        m_grant = 1;
          ib = (m_grant == 1);
          db = (m_grant == 2 || m_grant == 3);
        end
        1, 2: begin
          ib = (m_owner == 1);
          db = (m_owner == 2);
          if (m_iss < 8) begin
            en = 1;
            addr = m_base + 16'(2 * m_iss);
          end
          if (bus.mem_data_valid) begin
            idwe = ib; ddwe = db;
            itwe = ib && (m_rcv == 7);
            dtwe = db && (m_rcv == 7);
            faddr = m_base + 16'(2 * m_rcv);
          end
        end
        default: begin
          en = 1; wr = 1; addr = m_waddr; din = m_wdata; db = 1; ack = 1;
        end
      endcase
    end
    exp_ctrl = {en, wr, addr, din, ib, db, idwe, ddwe, itwe, dtwe, ack};
    exp_fill = (idwe || ddwe) ? {faddr, mem_word(faddr)} : 32'h0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_owner = 0; m_iss = 0; m_rcv = 0; m_last_d = 0;
      return;
    end
    case (m_owner)
      0: begin
        m_owner = m_grant;
        if (m_grant == 1) m_base = bus.i_miss_addr & 16'hFFF0;
        if (m_grant == 2) m_base = bus.d_miss_addr & 16'hFFF0;
        if (m_grant == 3) begin m_waddr = bus.d_wr_addr; m_wdata = bus.d_wr_data; end
      end
      1, 2: begin
        if (m_iss < 8) m_iss++;
        if (bus.mem_data_valid) begin
          if (m_rcv == 7) begin
            m_last_d = (m_owner == 2);
            m_owner = 0; m_iss = 0; m_rcv = 0;
          end else begin
            m_rcv++;
          end
        end
      end
      default: begin m_owner = 0; m_last_d = 1; end
    endcase
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic tick();
    if (!stall_now && mq.size() > 0 && mq[0].ready <= cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_out   = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data_out   = 16'($urandom);
    end
    #1;
    o_en = bus.mem_enable; o_wr = bus.mem_wr; o_addr = bus.mem_addr; o_din = bus.mem_data_in;
    o_ib = bus.i_busy; o_db = bus.d_busy; o_idwe = bus.i_data_we; o_ddwe = bus.d_data_we;
    o_itwe = bus.i_tag_we; o_dtwe = bus.d_tag_we; o_ack = bus.d_wr_ack;
    o_faddr = bus.fill_addr; o_fdata = bus.fill_data; o_valid = bus.mem_data_valid;
    obs_ctrl = {o_en, o_wr, o_addr, o_din, o_ib, o_db, o_idwe, o_ddwe, o_itwe, o_dtwe, o_ack};
    obs_fill = (o_idwe || o_ddwe) ? {o_faddr, o_fdata} : 32'h0;
    model_expect();
    @(posedge clk);
    if (o_en && !o_wr) mq.push_back('{cyc + MEM_LATENCY, o_addr});
    model_update();
    cyc++;
    @(negedge clk);
    if (o_itwe) bus.i_miss_req = 1'b0;
    if (o_dtwe) bus.d_miss_req = 1'b0;
    if (o_ack)  bus.d_wr_req   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h1111;
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h2222;
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h3333; bus.d_wr_data = 16'h4444;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (obs_ctrl !== 41'h0) begin
        n_fail++; $display("FAIL reset_outputs k=%0d got=%h exp=0", k, obs_ctrl);
      end
    end
    bus.i_miss_req = 0; bus.d_miss_req = 0; bus.d_wr_req = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if ({obs_ctrl, bus.fill_addr} !== 57'h0) begin
        n_fail++; $display("FAIL reset_idle k=%0d got=%h fill_addr=%h exp=0", k, obs_ctrl, bus.fill_addr);
      end
    end
  endtask

  task automatic test_i_fill();
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h1234;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_tests++;
      if ({obs_ctrl, obs_fill} !== {exp_ctrl, exp_fill}) begin
        n_fail++; $display("FAIL i_fill_model k=%0d got=%h/%h exp=%h/%h", k, obs_ctrl, obs_fill, exp_ctrl, exp_fill);
      end
      if (k >= 1 && k <= 8) begin
        n_tests++;
        if ({o_en, o_wr, o_addr} !== {2'b10, 16'h1230 + 16'(2 * (k - 1))}) begin
          n_fail++; $display("FAIL i_fill_issue k=%0d got=%b%b/%h exp=%h", k, o_en, o_wr, o_addr, 16'h1230 + 16'(2 * (k - 1)));
        end
      end
      n_tests++;
      if ({o_idwe, o_itwe} !== {(k >= 5 && k <= 12), (k == 12)}) begin
        n_fail++; $display("FAIL i_fill_we k=%0d got=%b%b exp=%b%b", k, o_idwe, o_itwe, (k >= 5 && k <= 12), (k == 12));
      end
      if (k >= 5 && k <= 12) begin
        n_tests++;
        if (o_faddr !== 16'h1230 + 16'(2 * (k - 5))) begin
          n_fail++; $display("FAIL i_fill_addr k=%0d got=%h exp=%h", k, o_faddr, 16'h1230 + 16'(2 * (k - 5)));
        end
      end
      n_tests++;
      if ({o_db, o_ddwe, o_dtwe} !== 3'b000) begin
        n_fail++; $display("FAIL i_fill_dside k=%0d got=%b%b%b exp=000", k, o_db, o_ddwe, o_dtwe);
      end
    end
  endtask

  task automatic test_dual_miss();
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h1100;
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h2200;
    for (int k = 0; k < 27; k++) begin
      tick();
      n_tests++;
      if ({obs_ctrl, obs_fill} !== {exp_ctrl, exp_fill}) begin
        n_fail++; $display("FAIL dual_model k=%0d got=%h/%h exp=%h/%h", k, obs_ctrl, obs_fill, exp_ctrl, exp_fill);
      end
      n_tests++;
      if ({o_dtwe, o_itwe} !== {(k == 12), (k == 25)}) begin
        n_fail++; $display("FAIL dual_tag k=%0d got=%b%b exp=%b%b", k, o_dtwe, o_itwe, (k == 12), (k == 25));
      end
      if (k >= 13 && k <= 25) begin
        n_tests++;
        if (o_ib !== 1'b1) begin
          n_fail++; $display("FAIL dual_i_busy k=%0d got=%b exp=1", k, o_ib);
        end
      end
      if (k == 14) begin
        n_tests++;
        if ({o_en, o_addr} !== {1'b1, 16'h1100}) begin
          n_fail++; $display("FAIL dual_i_issue got=%b/%h exp=1/1100", o_en, o_addr);
        end
      end
    end
  endtask

  task automatic test_write_then_fill();
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF;
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h0100;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_tests++;
      if ({obs_ctrl, obs_fill} !== {exp_ctrl, exp_fill}) begin
        n_fail++; $display("FAIL wr_model k=%0d got=%h/%h exp=%h/%h", k, obs_ctrl, obs_fill, exp_ctrl, exp_fill);
      end
      n_tests++;
      if (o_ack !== (k == 1)) begin
        n_fail++; $display("FAIL wr_ack k=%0d got=%b exp=%b", k, o_ack, (k == 1));
      end
      if (k == 1) begin
        n_tests++;
        if ({o_en, o_wr, o_addr, o_din} !== {2'b11, 16'h0040, 16'hBEEF}) begin
          n_fail++; $display("FAIL wr_cycle got=%b%b/%h/%h exp=11/0040/beef", o_en, o_wr, o_addr, o_din);
        end
      end
      if (k == 2 || k == 3) begin
        n_tests++;
        if ({o_en, o_addr} !== ((k == 3) ? {1'b1, 16'h0100} : 17'h0)) begin
          n_fail++; $display("FAIL wr_fill_issue k=%0d got=%b/%h", k, o_en, o_addr);
        end
      end
    end
  endtask

  task automatic test_fairness();
    rst_n = 0; tick(); rst_n = 1;
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h2000;
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h3000;
    for (int k = 0; k < 40; k++) begin
      if (k == 13) begin bus.d_miss_req = 1; bus.d_miss_addr = 16'h4000; end
      tick();
      n_tests++;
      if ({obs_ctrl, obs_fill} !== {exp_ctrl, exp_fill}) begin
        n_fail++; $display("FAIL fair_model k=%0d got=%h/%h exp=%h/%h", k, obs_ctrl, obs_fill, exp_ctrl, exp_fill);
      end
      if (k == 13 || k == 26) begin
        n_tests++;
        if ({o_ib, o_db} !== ((k == 13) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL fair_grant k=%0d got=%b%b", k, o_ib, o_db);
        end
      end
      if (k == 27) begin
        n_tests++;
        if ({o_en, o_addr} !== {1'b1, 16'h4000}) begin
          n_fail++; $display("FAIL fair_second_d got=%b/%h exp=1/4000", o_en, o_addr);
        end
      end
      if (k == 38) begin
        n_tests++;
        if (o_dtwe !== 1'b1) begin
          n_fail++; $display("FAIL fair_second_tag got=%b exp=1", o_dtwe);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h5678;
    for (int k = 0; k < 21; k++) begin
      if (k == 6) begin rst_n = 0; bus.i_miss_req = 0; end
      if (k == 7) rst_n = 1;
      tick();
      n_tests++;
      if ({obs_ctrl, obs_fill} !== {exp_ctrl, exp_fill}) begin
        n_fail++; $display("FAIL rstmid_model k=%0d got=%h/%h exp=%h/%h", k, obs_ctrl, obs_fill, exp_ctrl, exp_fill);
      end
      if (k >= 6) begin
        n_tests++;
        if (obs_ctrl !== 41'h0) begin
          n_fail++; $display("FAIL rstmid_quiet k=%0d valid=%b got=%h exp=0", k, o_valid, obs_ctrl);
        end
      end
    end
  endtask

  task automatic test_stall();
    int n_we, n_tag;
    n_we = 0; n_tag = 0;
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h7770;
    for (int k = 0; k < 17; k++) begin
      stall_now = (k == 7 || k == 8);
      tick();
      if (o_idwe) n_we++;
      if (o_itwe) n_tag++;
      n_tests++;
      if ({obs_ctrl, obs_fill} !== {exp_ctrl, exp_fill}) begin
        n_fail++; $display("FAIL stall_model k=%0d got=%h/%h exp=%h/%h", k, obs_ctrl, obs_fill, exp_ctrl, exp_fill);
      end
      n_tests++;
      if (o_itwe !== (k == 14)) begin
        n_fail++; $display("FAIL stall_tag k=%0d got=%b exp=%b", k, o_itwe, (k == 14));
      end
    end
    stall_now = 0;
    n_tests++;
    if ({n_we, n_tag} !== {32'd8, 32'd1}) begin
      n_fail++; $display("FAIL stall_counts got we=%0d tag=%0d exp we=8 tag=1", n_we, n_tag);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1040; k++) begin
      if (k < 1000) begin
        if (!bus.i_miss_req && $urandom_range(7) == 0) begin
          bus.i_miss_req = 1; bus.i_miss_addr = 16'($urandom);
        end
        if (!bus.d_miss_req && $urandom_range(7) == 0) begin
          bus.d_miss_req = 1; bus.d_miss_addr = 16'($urandom);
        end
        if (!bus.d_wr_req && $urandom_range(9) == 0) begin
          bus.d_wr_req = 1; bus.d_wr_addr = 16'($urandom); bus.d_wr_data = 16'($urandom);
        end
        stall_now = ($urandom_range(4) == 0);
      end else begin
        stall_now = 0;
      end
      tick();
      n_tests++;
      if ({obs_ctrl, obs_fill} !== {exp_ctrl, exp_fill}) begin
        n_fail++; $display("FAIL random_model k=%0d got=%h/%h exp=%h/%h", k, obs_ctrl, obs_fill, exp_ctrl, exp_fill);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; stall_now = 0;
    m_owner = 0; m_grant = 0; m_iss = 0; m_rcv = 0; m_last_d = 0;
    m_base = 16'h0; m_waddr = 16'h0; m_wdata = 16'h0;
    rst_n = 0;
    bus.i_miss_req = 0; bus.i_miss_addr = 16'h0;
    bus.d_miss_req = 0; bus.d_miss_addr = 16'h0;
    bus.d_wr_req = 0; bus.d_wr_addr = 16'h0; bus.d_wr_data = 16'h0;
    bus.mem_data_valid = 0; bus.mem_data_out = 16'h0;
    @(negedge clk);
    test_reset();
    test_i_fill();
    test_dual_miss();
    test_write_then_fill();
    test_fairness();
    test_reset_mid_fill();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
